// File: rtl/codec_pkg.sv
// Shared state type and frame constants for the codec transmitter.
package codec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } codec_state_t;

   localparam int SAMPLE_W_DEFAULT = 16;
   localparam int BITS_PER_FRAME   = 2 * SAMPLE_W_DEFAULT;

endpackage

// File: rtl/codec_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV clk cycles while enabled.
// rise/fall flag the clk edge at which bclk is about to change.
module codec_bclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic bclk,
   output logic rise,
   output logic fall
);

   logic [7:0] div_cnt;
   logic       toggle;

   assign toggle = enable && (div_cnt == 8'(CLK_DIV - 1));
   assign rise   = toggle & ~bclk;
   assign fall   = toggle & bclk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (toggle) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/codec_tx.sv
// Mono-to-stereo serial codec transmitter (left-justified by default).
// Define CODEC_TX_I2S_DELAY_EN for I2S format: sdata lags lrclk by one bclk.
module codec_tx
   import codec_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                new_sample_ready,
   input  logic                clear_flags,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                frame_start,
   output logic                overrun,
   output logic                underrun
);

   localparam int               CNT_W    = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

   codec_state_t        state;
   logic                nsr_prev;
   logic                hold_valid;
   logic [SAMPLE_W-1:0] hold;
   logic [SAMPLE_W-1:0] shift;
   logic [SAMPLE_W-1:0] saved;
   logic [CNT_W-1:0]    bit_cnt;
   logic                capture;
   logic                enable;
   logic                fall;
   logic                rise_unused;
   logic                slot_end;
   logic                frame_load;

   codec_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bclk   (bclk),
      .rise   (rise_unused),
      .fall   (fall)
   );

   assign capture    = new_sample_ready & ~nsr_prev;
   assign enable     = (state != ST_IDLE);
   assign slot_end   = fall && (bit_cnt == LAST_BIT);
   // A frame load pulls a new word from hold: leaving IDLE, or the RIGHT->LEFT wrap.
   assign frame_load = (state == ST_IDLE) ? hold_valid : ((state == ST_RIGHT) && slot_end);
   assign lrclk      = (state == ST_RIGHT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         nsr_prev    <= 1'b0;
         hold_valid  <= 1'b0;
         hold        <= '0;
         shift       <= '0;
         saved       <= '0;
         bit_cnt     <= '0;
         frame_start <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         nsr_prev    <= new_sample_ready;
         frame_start <= frame_load;

         // Clear first so that any flag set later in this block wins.
         if (clear_flags) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
         end

         if (capture) begin
            hold       <= sample_in;
            hold_valid <= 1'b1;
            if (hold_valid && !frame_load)
               overrun <= 1'b1;
         end else if (frame_load) begin
            hold_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (hold_valid) begin
                  state   <= ST_LEFT;
                  shift   <= hold;
                  saved   <= hold;
                  bit_cnt <= '0;
               end
            end
            ST_LEFT: begin
               if (slot_end) begin
                  state   <= ST_RIGHT;
                  shift   <= saved;
                  bit_cnt <= '0;
               end else if (fall) begin
                  shift   <= {shift[SAMPLE_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_RIGHT: begin
               if (slot_end) begin
                  state   <= ST_LEFT;
                  bit_cnt <= '0;
                  if (hold_valid) begin
                     shift <= hold;
                     saved <= hold;
                  end else begin
                     shift    <= saved;
                     underrun <= 1'b1;
                  end
               end else if (fall) begin
                  shift   <= {shift[SAMPLE_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef CODEC_TX_I2S_DELAY_EN
   // Retains the bit just finished so each slot starts with the previous slot's LSB.
   logic delay_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         delay_bit <= 1'b0;
      else if (fall)
         delay_bit <= shift[SAMPLE_W-1];
   end

   assign sdata = delay_bit;
`else
   assign sdata = shift[SAMPLE_W-1];
`endif

endmodule

// File: tb/tb_codec_tx.sv
// Self-checking bench for codec_tx: a CLK_DIV=4 and a CLK_DIV=2 instance, each
// compared cycle by cycle against a frame-level model of the serial output.
module tb_codec_tx;

   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_slow, rst_fast;
   logic [W-1:0] sample_in;
   logic         nsr, clear_flags;
   logic         s_bclk, s_lrclk, s_sdata, s_fs, s_ov, s_un;
   logic         f_bclk, f_lrclk, f_sdata, f_fs, f_ov, f_un;

   codec_tx #(.CLK_DIV(4), .SAMPLE_W(W)) dut_slow (
      .clk(clk), .reset(rst_slow), .sample_in(sample_in), .new_sample_ready(nsr),
      .clear_flags(clear_flags), .bclk(s_bclk), .lrclk(s_lrclk), .sdata(s_sdata),
      .frame_start(s_fs), .overrun(s_ov), .underrun(s_un)
   );

   codec_tx #(.CLK_DIV(2), .SAMPLE_W(W)) dut_fast (
      .clk(clk), .reset(rst_fast), .sample_in(sample_in), .new_sample_ready(nsr),
      .clear_flags(clear_flags), .bclk(f_bclk), .lrclk(f_lrclk), .sdata(f_sdata),
      .frame_start(f_fs), .overrun(f_ov), .underrun(f_un)
   );

   int errors = 0;
   int checks = 0;
   bit use_fast;
   int div;

   // Reference model state: word on the wire this frame, pending hold, flags.
   logic [W-1:0] m_cur, m_hold;
   bit           m_hv, m_ov, m_un, m_prev_lsb;

   function automatic logic [5:0] observed();
      return use_fast ? {f_fs, f_bclk, f_lrclk, f_sdata, f_ov, f_un}
                      : {s_fs, s_bclk, s_lrclk, s_sdata, s_ov, s_un};
   endfunction

   task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h (fs,bclk,lr,sd,ov,un for frame checks)",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cur = '0; m_hold = '0; m_hv = 0; m_ov = 0; m_un = 0; m_prev_lsb = 0;
   endtask

   // Expected sdata at cycle c of a frame, from slot position and bit index.
   function automatic logic exp_bit(input int c, input int d);
      int h;
      int k;
      h = W * 2 * d;
      k = (c % h) / (2 * d);
`ifdef CODEC_TX_I2S_DELAY_EN
      if (k == 0) return (c < h) ? m_prev_lsb : m_cur[0];
      return m_cur[W-k];
`else
      return m_cur[W-1-k];
`endif
   endfunction

   // Strobe from IDLE; leaves the bench at cycle 0 of the first frame.
   task automatic start_from_idle(input logic [W-1:0] val);
      nsr = 1'b1; sample_in = val;
      @(negedge clk);
      check("idle_capture", 0, 32'(observed()), 32'({4'b0000, m_ov, m_un}));
      nsr = 1'b0;
      @(negedge clk);
      m_cur = val; m_hv = 0; m_prev_lsb = 0;
   endtask

   // Runs ncyc cycles of one frame; strobes at s1c/s2c and clear at clrc (-1 = none).
   task automatic run_frame(input int ncyc, input int s1c, input logic [W-1:0] s1v,
                            input int s2c, input logic [W-1:0] s2v, input int clrc);
      int n, h;
      logic [5:0] exp_v, obs_v;
      logic [W-1:0] wl, wr, f_cur;
      bit f_prev;
      n = 4 * W * div;
      h = 2 * W * div;
      wl = '0; wr = '0;
      f_cur = m_cur; f_prev = m_prev_lsb;
      for (int c = 0; c < ncyc; c++) begin
         exp_v = {c == 0, ((c / div) % 2) == 1, c >= h, exp_bit(c, div), m_ov, m_un};
         obs_v = observed();
         check("frame", c, 32'(obs_v), 32'(exp_v));
         if ((c % (2 * div)) == div) begin
            if (c < h) wl = {wl[W-2:0], obs_v[2]};
            else       wr = {wr[W-2:0], obs_v[2]};
         end
         nsr         = (c == s1c) || (c == s2c);
         sample_in   = (c == s2c) ? s2v : s1v;
         clear_flags = (c == clrc);
         if (c == clrc) begin m_ov = 0; m_un = 0; end
         if (c == n - 1) begin
            m_prev_lsb = m_cur[0];
            if (m_hv) begin m_cur = m_hold; m_hv = 0; end
            else m_un = 1;
            if (nsr) begin m_hold = sample_in; m_hv = 1; end
         end else if (nsr) begin
            if (m_hv) m_ov = 1;
            m_hold = sample_in; m_hv = 1;
         end
         @(negedge clk);
      end
      nsr = 1'b0; clear_flags = 1'b0;
      if (ncyc == n) begin
`ifdef CODEC_TX_I2S_DELAY_EN
         check("word_left", 0, 32'(wl), 32'({f_prev, f_cur[W-1:1]}));
         check("word_right", 0, 32'(wr), 32'({f_cur[0], f_cur[W-1:1]}));
`else
         check("word_left", 0, 32'(wl), 32'(f_cur));
         check("word_right", 0, 32'(wr), 32'(f_cur));
`endif
      end
   endtask

   initial begin
      int n;
      logic [W-1:0] rv;
      nsr = 0; clear_flags = 0; sample_in = '0;
      rst_slow = 0; rst_fast = 0; use_fast = 0; div = 4;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", 0, 32'(observed()), 32'd0);
      rst_slow = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_hold", i, 32'(observed()), 32'd0);
      end
      n = 4 * W * div;

      // A5C3 on both slots, then an underrun repeat cleared mid-frame.
      start_from_idle(16'hA5C3);
      run_frame(n, -1, '0, -1, '0, -1);
      run_frame(n, -1, '0, -1, '0, 100);
      // Two strobes in one frame: overrun, newest word wins.
      run_frame(n, 10, 16'h0001, 100, 16'h0002, -1);
      run_frame(n, -1, '0, -1, '0, 5);
      // Strobe on the load cycle: old hold goes first, no overrun.
      run_frame(n, 20, 16'h1234, n - 1, 16'hBEEF, 3);
      run_frame(n, -1, '0, -1, '0, -1);
      run_frame(n, -1, '0, -1, '0, 7);

      for (int f = 0; f < 4; f++) begin
         int a, b, cl;
         a  = int'($urandom_range(1, 100));
         b  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(130, n - 1)) : -1;
         cl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         run_frame(n, a, W'($urandom), b, W'($urandom), cl);
      end

      // Reset in the middle of the RIGHT slot.
      run_frame(200, 30, W'($urandom), -1, '0, -1);
      rst_slow = 0;
      #1;
      check("reset_mid_right", 0, 32'(observed()), 32'd0);
      model_reset();
      @(negedge clk);
      rst_slow = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_after_reset", i, 32'(observed()), 32'd0);
      end
      start_from_idle(W'($urandom));
      run_frame(n, -1, '0, -1, '0, -1);

      // Strobe already high at reset release counts as a rising edge.
      rv = W'($urandom);
      rst_slow = 0; nsr = 1; sample_in = rv;
      repeat (2) @(negedge clk);
      model_reset();
      rst_slow = 1;
      start_from_idle(rv);
      run_frame(n, -1, '0, -1, '0, -1);

      // Fast instance: CLK_DIV=2.
      rst_slow = 0; use_fast = 1; div = 2; n = 4 * W * div;
      model_reset();
      @(negedge clk);
      check("fast_reset", 0, 32'(observed()), 32'd0);
      rst_fast = 1;
      start_from_idle(W'($urandom));
      run_frame(n, 40, W'($urandom), -1, '0, -1);
      run_frame(n, -1, '0, -1, '0, -1);
      run_frame(n, -1, '0, -1, '0, 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
